// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types, opcodes and select encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
        S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_MOVE_WB, S_HALT
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_MOVE = 6'b010001;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIFT = 2'd3;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       byte_op;
        logic       ir_write;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       move_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic is_byte(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - shared-memory request handshake between controller and memory block
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic byte_op;
    logic mem_ready;

    modport master (output mem_req, mem_we, iord, byte_op, input mem_ready);
    modport slave  (input mem_req, mem_we, iord, byte_op, output mem_ready);
endinterface

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational decode of FSM state and IR opcode into datapath controls
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic       en,
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       run,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (en) begin
            case (state)
                S_FETCH: if (run) begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.alu_src_b = SRCB_ONE;
                    ctrl.alu_op    = ALU_ADD;
                    // IR load and PC+1 commit in the cycle the word arrives
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_we    = 1'b1;
                        ctrl.pc_src   = PC_INC;
                    end
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_SHIFT;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.byte_op   = is_byte(opcode);
                end
                S_MEM_RD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.iord    = 1'b1;
                    ctrl.byte_op = is_byte(opcode);
                end
                S_MEM_WR: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.mem_we  = 1'b1;
                    ctrl.iord    = 1'b1;
                    ctrl.byte_op = is_byte(opcode);
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.byte_op    = is_byte(opcode);
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_ANDI: ctrl.alu_op = ALU_AND;
                        OP_ORI:  ctrl.alu_op = ALU_OR;
                        OP_SLTI: ctrl.alu_op = ALU_SLT;
                        default: ctrl.alu_op = ALU_ADD;
                    endcase
                end
                S_I_WB: ctrl.reg_write = 1'b1;
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = PC_BRANCH;
                    ctrl.pc_we     = (opcode == OP_BNE) ? !zero : zero;
                end
                S_JUMP: begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = PC_JUMP;
                end
                S_MOVE_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.move_sel  = 1'b1;
                end
                S_HALT: ctrl.halted = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS sequencer; MIPS_CTRL_PERF_EN adds cycle/instruction counters
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    mips_multicycle_ctrl_if.master mem,
    output logic                   ir_write,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   move_sel,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_op,
    output logic                   halted
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0]            cycle_cnt,
    output logic [31:0]            instr_cnt
`endif
);

    // Last count before the watchdog saturates at 2^W-1 wait cycles
    localparam logic [MEM_TIMEOUT_W-1:0] WD_LAST = ~{{(MEM_TIMEOUT_W-1){1'b0}}, 1'b1};

    state_e                   state_q, state_d;
    logic [MEM_TIMEOUT_W-1:0] wd_q, wd_d;
    ctrl_t                    ctrl;

    // Outputs are forced low for as long as reset is held, independent of run
    mips_ctrl_outdec u_outdec (
        .en        (rst_n),
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem.mem_ready),
        .run       (run),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (run && mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:                           state_d = S_EXEC_R;
                    OP_LW, OP_LB, OP_SW, OP_SB:     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                 state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_J:                           state_d = S_JUMP;
                    OP_MOVE:                        state_d = S_MOVE_WB;
                    default:                        state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: state_d = is_store(opcode) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        if (ctrl.mem_req && !mem.mem_ready && (wd_q == WD_LAST)) state_d = S_HALT;

        if (mem.mem_ready)     wd_d = '0;
        else if (ctrl.mem_req) wd_d = wd_q + 1'b1;
        else                   wd_d = wd_q;
    end

`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = (state_q != S_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instr_cnt_d = (state_q != S_FETCH && state_d == S_FETCH) ? instr_cnt_q + 32'd1 : instr_cnt_q;
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wd_q    <= '0;
`ifdef MIPS_CTRL_PERF_EN
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
`ifdef MIPS_CTRL_PERF_EN
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
`endif
        end
    end

    assign mem.mem_req = ctrl.mem_req;
    assign mem.mem_we  = ctrl.mem_we;
    assign mem.iord    = ctrl.iord;
    assign mem.byte_op = ctrl.byte_op;
    assign ir_write    = ctrl.ir_write;
    assign pc_we       = ctrl.pc_we;
    assign pc_src      = ctrl.pc_src;
    assign reg_write   = ctrl.reg_write;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign move_sel    = ctrl.move_sel;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign halted      = ctrl.halted;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        ir_write, pc_we, reg_write, reg_dst, mem_to_reg, move_sel, alu_src_a, halted;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_op;
    logic [18:0] got;
    int          checks = 0;
    int          errors = 0;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mips_multicycle_ctrl_if ifc ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (ifc.master),
        .ir_write   (ir_write),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .move_sel   (move_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .halted     (halted)
`ifdef MIPS_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign got = {ifc.mem_req, ifc.mem_we, ifc.iord, ifc.byte_op, ir_write, pc_we, pc_src,
                  reg_write, reg_dst, mem_to_reg, move_sel, alu_src_a, alu_src_b, alu_op, halted};

    function automatic logic [18:0] mk(input logic req, we, io, by, irw, pcwe, input logic [1:0] pcs,
                                       input logic rw, rd, m2r, mv, sa, input logic [1:0] sb,
                                       input logic [2:0] op, input logic h);
        return {req, we, io, by, irw, pcwe, pcs, rw, rd, m2r, mv, sa, sb, op, h};
    endfunction

    // Expected output vectors per state: ALUop ADD=0 SUB=1 FUNCT=2 AND=3 OR=4; srcB RT=0 ONE=1 IMM=2 SHIFT=3
    localparam logic [18:0] Z       = 19'd0;
    localparam logic [18:0] F_RDY   = mk(1,0,0,0,1,1,2'd0,0,0,0,0,0,2'd1,3'd0,0);
    localparam logic [18:0] F_WAIT  = mk(1,0,0,0,0,0,2'd0,0,0,0,0,0,2'd1,3'd0,0);
    localparam logic [18:0] DEC     = mk(0,0,0,0,0,0,2'd0,0,0,0,0,0,2'd3,3'd0,0);
    localparam logic [18:0] EXR     = mk(0,0,0,0,0,0,2'd0,0,0,0,0,1,2'd0,3'd2,0);
    localparam logic [18:0] RWB     = mk(0,0,0,0,0,0,2'd0,1,1,0,0,0,2'd0,3'd0,0);
    localparam logic [18:0] MADDR   = mk(0,0,0,0,0,0,2'd0,0,0,0,0,1,2'd2,3'd0,0);
    localparam logic [18:0] MADDR_B = mk(0,0,0,1,0,0,2'd0,0,0,0,0,1,2'd2,3'd0,0);
    localparam logic [18:0] MRD     = mk(1,0,1,0,0,0,2'd0,0,0,0,0,0,2'd0,3'd0,0);
    localparam logic [18:0] MWB     = mk(0,0,0,0,0,0,2'd0,1,0,1,0,0,2'd0,3'd0,0);
    localparam logic [18:0] MWR     = mk(1,1,1,0,0,0,2'd0,0,0,0,0,0,2'd0,3'd0,0);
    localparam logic [18:0] MWR_B   = mk(1,1,1,1,0,0,2'd0,0,0,0,0,0,2'd0,3'd0,0);
    localparam logic [18:0] BR0     = mk(0,0,0,0,0,0,2'd1,0,0,0,0,1,2'd0,3'd1,0);
    localparam logic [18:0] BR1     = mk(0,0,0,0,0,1,2'd1,0,0,0,0,1,2'd0,3'd1,0);
    localparam logic [18:0] JMP     = mk(0,0,0,0,0,1,2'd2,0,0,0,0,0,2'd0,3'd0,0);
    localparam logic [18:0] MVWB    = mk(0,0,0,0,0,0,2'd0,1,0,0,1,0,2'd0,3'd0,0);
    localparam logic [18:0] EXI_ADD = mk(0,0,0,0,0,0,2'd0,0,0,0,0,1,2'd2,3'd0,0);
    localparam logic [18:0] EXI_OR  = mk(0,0,0,0,0,0,2'd0,0,0,0,0,1,2'd2,3'd4,0);
    localparam logic [18:0] IWB     = mk(0,0,0,0,0,0,2'd0,1,0,0,0,0,2'd0,3'd0,0);
    localparam logic [18:0] HLT     = mk(0,0,0,0,0,0,2'd0,0,0,0,0,0,2'd0,3'd0,1);

    typedef struct {
        logic [18:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    // Monitor: compares DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s got %b want %b", e.name, got, e.exp);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] o, input logic z, input logic rd,
                        input logic [18:0] e, input string n);
        run = r; opcode = o; zero = z; ifc.mem_ready = rd;
        sb.push_back('{e, n});
        @(posedge clk); #1;
    endtask

`ifdef MIPS_CTRL_PERF_EN
    task automatic chk32(input string n, input logic [31:0] g, input logic [31:0] w);
        checks++;
        if (g !== w) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, g, w);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; run = 1'b1; opcode = 6'd0; zero = 1'b0; ifc.mem_ready = 1'b1;
        @(posedge clk); #1;
        step(1, 6'o00, 0, 1, Z, "reset_state");
        rst_n = 1'b1;
        step(0, 6'o00, 0, 1, Z, "idle_rdy_ignored");
        step(0, 6'o00, 0, 0, Z, "idle");
        // R-type
        step(1, 6'b000000, 0, 1, F_RDY, "r_fetch");
        step(1, 6'b000000, 0, 1, DEC,   "r_dec");
        step(1, 6'b000000, 0, 1, EXR,   "r_exec");
        step(1, 6'b000000, 0, 1, RWB,   "r_wb");
        // lw with three wait cycles
        step(1, 6'b100011, 0, 1, F_RDY, "lw_fetch");
        step(1, 6'b100011, 0, 1, DEC,   "lw_dec");
        step(1, 6'b100011, 0, 1, MADDR, "lw_addr");
        for (int i = 0; i < 3; i++) step(1, 6'b100011, 0, 0, MRD, "lw_wait");
        step(1, 6'b100011, 0, 1, MRD,   "lw_rd");
        step(1, 6'b100011, 0, 1, MWB,   "lw_wb");
        // sb
        step(1, 6'b101000, 0, 1, F_RDY,   "sb_fetch");
        step(1, 6'b101000, 0, 1, DEC,     "sb_dec");
        step(1, 6'b101000, 0, 1, MADDR_B, "sb_addr");
        step(1, 6'b101000, 0, 1, MWR_B,   "sb_wr");
        // beq not taken, bne taken, beq taken
        step(1, 6'b000100, 0, 1, F_RDY, "beq_fetch");
        step(1, 6'b000100, 0, 1, DEC,   "beq_dec");
        step(1, 6'b000100, 0, 1, BR0,   "beq_not_taken");
        step(1, 6'b000101, 0, 1, F_RDY, "bne_fetch");
        step(1, 6'b000101, 0, 1, DEC,   "bne_dec");
        step(1, 6'b000101, 0, 1, BR1,   "bne_taken");
        step(1, 6'b000100, 1, 1, F_RDY, "beq2_fetch");
        step(1, 6'b000100, 1, 1, DEC,   "beq2_dec");
        step(1, 6'b000100, 1, 1, BR1,   "beq_taken");
        // j with run dropped mid-instruction
        step(1, 6'b000010, 0, 1, F_RDY, "j_fetch");
        step(0, 6'b000010, 0, 1, DEC,   "j_dec_run0");
        step(0, 6'b000010, 0, 1, JMP,   "j_jump_run0");
        step(0, 6'b000010, 0, 1, Z,     "idle_after_j");
        // move, addi, ori
        step(1, 6'b010001, 0, 1, F_RDY,   "mv_fetch");
        step(1, 6'b010001, 0, 1, DEC,     "mv_dec");
        step(1, 6'b010001, 0, 1, MVWB,    "mv_wb");
        step(1, 6'b001000, 0, 1, F_RDY,   "addi_fetch");
        step(1, 6'b001000, 0, 1, DEC,     "addi_dec");
        step(1, 6'b001000, 0, 1, EXI_ADD, "addi_exec");
        step(1, 6'b001000, 0, 1, IWB,     "addi_wb");
        step(1, 6'b001101, 0, 1, F_RDY,   "ori_fetch");
        step(1, 6'b001101, 0, 1, DEC,     "ori_dec");
        step(1, 6'b001101, 0, 1, EXI_OR,  "ori_exec");
        step(1, 6'b001101, 0, 1, IWB,     "ori_wb");
`ifdef MIPS_CTRL_PERF_EN
        chk32("instr_cnt_10", instr_cnt, 32'd10);
`endif
        // illegal opcode halts; run toggling has no effect
        step(1, 6'b111111, 0, 1, F_RDY, "ill_fetch");
        step(1, 6'b111111, 0, 1, DEC,   "ill_dec");
        step(1, 6'b111111, 0, 1, HLT,   "halt");
        step(0, 6'b111111, 0, 1, HLT,   "halt_run0");
        step(1, 6'b111111, 0, 1, HLT,   "halt_run1");
        rst_n = 1'b0;
        step(1, 6'b000000, 0, 1, Z, "halt_reset");
        rst_n = 1'b1;
        // sw waiting, reset mid-request
        step(1, 6'b101011, 0, 1, F_RDY, "sw_fetch");
        step(1, 6'b101011, 0, 1, DEC,   "sw_dec");
        step(1, 6'b101011, 0, 1, MADDR, "sw_addr");
        step(1, 6'b101011, 0, 0, MWR,   "sw_wait1");
        step(1, 6'b101011, 0, 0, MWR,   "sw_wait2");
        rst_n = 1'b0;
        step(1, 6'b101011, 0, 0, Z, "sw_reset_drop");
        rst_n = 1'b1;
        step(1, 6'b000000, 0, 1, F_RDY, "restart_fetch");
        step(1, 6'b000000, 0, 1, DEC,   "restart_dec");
        step(1, 6'b000000, 0, 1, EXR,   "restart_exec");
        step(1, 6'b000000, 0, 1, RWB,   "restart_wb");
`ifdef MIPS_CTRL_PERF_EN
        chk32("instr_cnt_after_rst", instr_cnt, 32'd1);
`endif
        // watchdog: 255 unanswered fetch cycles
        rst_n = 1'b0;
        step(0, 6'b000000, 0, 0, Z, "wd_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 255; i++) step(1, 6'b000000, 0, 0, F_WAIT, "wd_wait");
        step(1, 6'b000000, 0, 1, HLT, "wd_halt");
        step(0, 6'b000000, 0, 1, HLT, "wd_halt_hold");
`ifdef MIPS_CTRL_PERF_EN
        chk32("wd_instr_cnt", instr_cnt, 32'd0);
        chk32("wd_cycle_cnt", cycle_cnt, 32'd255);
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle opcode decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and write-back. It issues one shared-memory request at a time over a req/ready handshake and drives every datapath select and strobe. It sits between the instruction register opcode field and the datapath muxes, register file, ALU control and memory block.

## Interface
Parameters:
- `MEM_TIMEOUT_W`, 8: width of the memory-wait watchdog counter. A wait of 2^W−1 cycles without `mem_ready` halts the core.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  permits starting a new instruction; sampled in FETCH only
- `opcode`  in  6  instruction[31:26] from the IR
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  request is a write
- `iord`  out  1  address select: 0 = PC, 1 = ALU result register
- `byte_op`  out  1  byte-width load/store
- `ir_write`  out  1  latch fetched word into IR
- `pc_we`  out  1  PC write enable, with branch qualification already applied
- `pc_src`  out  2  PC source: INC / BRANCH / JUMP
- `reg_write`  out  1  register file write strobe
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  write-back from memory data register
- `move_sel`  out  1  write-back from readData1
- `alu_src_a`  out  1  0 = PC, 1 = rs
- `alu_src_b`  out  2  rt / const-1 / sign-extended imm / shifted imm
- `alu_op`  out  3  ALUop to the ALU control
- `halted`  out  1  sticky halt indication

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, MOVE_WB, HALT.
- FETCH: waits while `run`=0, with no strobes. When `run`=1:
  - drives `mem_req`=1, `iord`=0, `mem_we`=0.
  - When `mem_ready`=1 it asserts `ir_write`, `pc_we` and `pc_src`=INC in the same cycle, then moves to DECODE.
- DECODE: `alu_src_a`=0 and `alu_src_b`=shifted imm precompute the branch target. The next state is chosen by opcode:
  - R (000000) → EXEC_R
  - lw/lb (100011/100000) and sw/sb (101011/101000) → MEM_ADDR
  - beq/bne (000100/000101) → BRANCH
  - addi/andi/ori/slti (001000/001100/001101/001010) → EXEC_I
  - j (000010) → JUMP
  - move (010001) → MOVE_WB
  - any other opcode → HALT
- MEM_ADDR → MEM_RD for loads, MEM_WR for stores.
- MEM_RD and MEM_WR hold `mem_req`=1 and `iord`=1 until `mem_ready`. Loads then go to MEM_WB; stores go to FETCH.
- `byte_op`=1 throughout lb/sb.
- Write-back states (`reg_write`=1, one cycle, then FETCH):
  - MEM_WB: `mem_to_reg`=1.
  - R_WB: `reg_dst`=1.
  - I_WB: `reg_dst`=0.
  - MOVE_WB: `move_sel`=1.
- BRANCH:
  - `pc_src`=BRANCH.
  - `pc_we` = `zero` for beq, = !`zero` for bne.
  - Next state FETCH.
- JUMP: `pc_we`=1, `pc_src`=JUMP, next state FETCH.
- HALT: all strobes 0, `halted`=1. Left only by reset.
- Memory watchdog: counts cycles with `mem_req`=1 and `mem_ready`=0. It clears on every `mem_ready`; saturation forces HALT.

## Timing
- Reset: state=FETCH and every output is 0, asynchronously on `rst_n` fall, including mid-instruction and mid-request. A partially executed instruction is abandoned.
- `mem_req`, `iord`, `mem_we` and `byte_op` are Moore outputs, stable for the whole request.
- `ir_write` and FETCH `pc_we` are Mealy outputs on `mem_ready`.
- Latency with zero memory wait:
  - R, I, lw-class: 4 / 4 / 5 cycles
  - sw-class: 4 cycles
  - beq/bne, j, move: 3 cycles
- Each memory wait cycle adds one cycle.
- `run` deasserted mid-instruction: the instruction completes; the FSM idles in FETCH.
- `mem_ready` outside a request is ignored.

## Configuration
- `MIPS_CTRL_PERF_EN` defined: adds outputs `cycle_cnt[31:0]` and `instr_cnt[31:0]`.
  - Both reset to 0 and wrap at 2^32.
  - `cycle_cnt` increments every cycle not in HALT.
  - `instr_cnt` increments on each entry to FETCH from a completing state.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Package `mips_ctrl_pkg`:
  - state enum
  - opcode constants
  - ALUop encodings (ADD, SUB, FUNCT, AND, OR, SLT)
  - `pc_src` and `alu_src_b` encodings
- Sub-module `mips_ctrl_outdec`: combinational decode of state, opcode, `zero` and `mem_ready` into all outputs. The top keeps the state register, next-state logic, watchdog and counters.

## Test plan
- `run`=1, `opcode`=000000, `mem_ready`=1 always → FETCH, DECODE, EXEC_R, R_WB; `reg_write`=1 with `reg_dst`=1 in cycle 4; back to FETCH.
- lw with `mem_ready` low for 3 cycles in MEM_RD → `mem_req`, `iord`=1 stable for 4 cycles; total 8 cycles; MEM_WB `mem_to_reg`=1.
- beq with `zero`=0, then bne with `zero`=0 → `pc_we`=0 for beq; `pc_we`=1 with `pc_src`=BRANCH for bne.
- `opcode`=111111 → HALT after DECODE, `halted`=1; `run` toggling has no effect until `rst_n`=0.
- `rst_n` asserted during MEM_WR wait → `mem_req` drops immediately; next start is FETCH.
- `mem_ready` held 0 for 255 cycles with `MEM_TIMEOUT_W`=8 → HALT. With `MIPS_CTRL_PERF_EN`, `instr_cnt` equals the number of completed instructions.
